// File: rtl/vend_fsm_multi_pkg.sv
// Shared types and constants for the multi-item vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        READY    = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_t;

    localparam int unsigned TEA    = 0;
    localparam int unsigned COKE   = 1;
    localparam int unsigned COFFEE = 2;
    localparam int unsigned MILK   = 3;

    localparam logic [7:0] PRICE_TEA    = 8'd10;
    localparam logic [7:0] PRICE_COKE   = 8'd15;
    localparam logic [7:0] PRICE_COFFEE = 8'd20;
    localparam logic [7:0] PRICE_MILK   = 8'd25;

    localparam logic [31:0] DEFAULT_PRICES = {PRICE_MILK, PRICE_COFFEE, PRICE_COKE, PRICE_TEA};

    localparam int unsigned PRICE_TABLE_W = 1024;

    // Smallest of n packed w-bit entries; evaluated at elaboration only.
    function automatic int unsigned min_price(input logic [PRICE_TABLE_W-1:0] price_bits,
                                              input int unsigned n,
                                              input int unsigned w);
        int unsigned m;
        logic [PRICE_TABLE_W-1:0] mask;
        m = 32'hFFFF_FFFF;
        mask = (PRICE_TABLE_W'(1) << w) - PRICE_TABLE_W'(1);
        for (int unsigned i = 0; i < n; i++) begin
            int unsigned p;
            p = 32'((price_bits >> (i * w)) & mask);
            if (p < m) m = p;
        end
        return m;
    endfunction

endpackage

// File: rtl/vend_fsm_multi_if.sv
// Coin/selection/dispense bus between the front-end, the controller and the dispensers.
interface vend_fsm_multi_if #(
    parameter int unsigned N_DRINKS = 4,
    parameter int unsigned MONEY_W  = 8
);
    localparam int unsigned SEL_W = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1;

    logic               coin_valid;
    logic [MONEY_W-1:0] coin;
    logic               coin_ready;
    logic               coin_reject;
    logic               sel_valid;
    logic [SEL_W-1:0]   sel;
    logic               cancel;
    logic [MONEY_W-1:0] total_coin;
    logic [N_DRINKS-1:0] avail;
    logic               sel_err;
    logic               dispense_valid;
    logic [SEL_W-1:0]   dispense_id;
    logic               change_valid;
    logic [MONEY_W-1:0] change;

    modport master (
        output coin_valid, coin, sel_valid, sel, cancel,
        input  coin_ready, coin_reject, total_coin, avail, sel_err,
               dispense_valid, dispense_id, change_valid, change
    );

    modport slave (
        input  coin_valid, coin, sel_valid, sel, cancel,
        output coin_ready, coin_reject, total_coin, avail, sel_err,
               dispense_valid, dispense_id, change_valid, change
    );

endinterface

// File: rtl/vend_fsm_multi_price_table.sv
// Combinational price comparators: affordability mask plus the price/affordability of the selected item.
module vend_price_table #(
    parameter int unsigned N_DRINKS = 4,
    parameter int unsigned MONEY_W  = 8,
    parameter logic [N_DRINKS*MONEY_W-1:0] PRICES = '0,
    localparam int unsigned SEL_W = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1
) (
    input  logic [MONEY_W-1:0]  total,
    input  logic [SEL_W-1:0]    sel,
    output logic [N_DRINKS-1:0] avail,
    output logic                sel_avail,
    output logic [MONEY_W-1:0]  sel_price
);
    localparam int unsigned N_SLOTS = 1 << SEL_W;

    // Indices past N_DRINKS decode to unaffordable, zero-priced slots.
    logic [N_SLOTS-1:0] avail_ext;
    logic [MONEY_W-1:0] price_ext [N_SLOTS];

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        if (i < N_DRINKS) begin : g_item
            assign price_ext[i] = PRICES[i*MONEY_W +: MONEY_W];
            assign avail_ext[i] = (total >= price_ext[i]);
        end else begin : g_empty
            assign price_ext[i] = '0;
            assign avail_ext[i] = 1'b0;
        end
    end

    assign avail     = avail_ext[N_DRINKS-1:0];
    assign sel_avail = avail_ext[sel];
    assign sel_price = price_ext[sel];

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-item vending controller: coin credit, selection, dispense and change refund.
// Define MULTI_BUY_EN to keep leftover credit for further purchases instead of refunding it.
module vend_fsm_multi
    import vend_pkg::*;
#(
    parameter int unsigned N_DRINKS   = 4,
    parameter int unsigned MONEY_W    = 8,
    parameter int unsigned MAX_CREDIT = 255,
    parameter logic [N_DRINKS*MONEY_W-1:0] PRICES = DEFAULT_PRICES
) (
    input  logic            clk,
    input  logic            reset,
    vend_fsm_multi_if.slave bus
);
    localparam int unsigned SEL_W = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1;
    localparam logic [PRICE_TABLE_W-1:0] PRICES_EXT = PRICE_TABLE_W'(PRICES);
    localparam logic [MONEY_W-1:0] MIN_PRICE = MONEY_W'(min_price(PRICES_EXT, N_DRINKS, MONEY_W));

    vend_state_t        state, state_nx;
    logic [MONEY_W-1:0] total, total_nx;
    logic [MONEY_W-1:0] change_q, change_nx;
    logic [SEL_W-1:0]   disp_id, disp_id_nx;
    logic               coin_reject_q, coin_reject_nx;
    logic               sel_err_q, sel_err_nx;

    logic               coin_ready;
    logic               coin_take;
    logic               coin_fits;
    logic [MONEY_W:0]   coin_sum;
    logic [MONEY_W-1:0] coin_add;
    logic [N_DRINKS-1:0] avail;
    logic               sel_avail;
    logic [MONEY_W-1:0] sel_price;

    vend_price_table #(
        .N_DRINKS (N_DRINKS),
        .MONEY_W  (MONEY_W),
        .PRICES   (PRICES)
    ) u_price_table (
        .total     (total),
        .sel       (bus.sel),
        .avail     (avail),
        .sel_avail (sel_avail),
        .sel_price (sel_price)
    );

    assign coin_ready     = (state == COLLECT) || (state == READY);
    assign coin_take      = bus.coin_valid && coin_ready;
    assign coin_sum       = {1'b0, total} + {1'b0, bus.coin};
    assign coin_fits      = (coin_sum <= (MONEY_W+1)'(MAX_CREDIT));
    assign coin_add       = (coin_take && coin_fits) ? bus.coin : '0;
    assign coin_reject_nx = coin_take && !coin_fits;

    always_comb begin
        state_nx   = state;
        total_nx   = total;
        change_nx  = change_q;
        disp_id_nx = disp_id;
        sel_err_nx = 1'b0;
        case (state)
            COLLECT: begin
                total_nx = total + coin_add;
                if (bus.cancel && (total != '0)) begin
                    state_nx = CHANGE;
                end else begin
                    sel_err_nx = bus.sel_valid;
                    if (total >= MIN_PRICE) state_nx = READY;
                end
            end
            READY: begin
                total_nx = total + coin_add;
                if (bus.cancel) begin
                    state_nx = CHANGE;
                end else if (bus.sel_valid) begin
                    // Affordability uses the pre-coin credit; the same-cycle coin still lands.
                    if (sel_avail) begin
                        total_nx   = total + coin_add - sel_price;
                        disp_id_nx = bus.sel;
                        state_nx   = DISPENSE;
                    end else begin
                        sel_err_nx = 1'b1;
                    end
                end
            end
            DISPENSE: begin
`ifdef MULTI_BUY_EN
                state_nx = (total >= MIN_PRICE) ? READY : COLLECT;
`else
                state_nx = (total != '0) ? CHANGE : COLLECT;
`endif
            end
            CHANGE: begin
                total_nx = '0;
                state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
        // Refund amount is captured on entry so it is valid alongside change_valid.
        if ((state_nx == CHANGE) && (state != CHANGE)) change_nx = total_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= COLLECT;
            total         <= '0;
            change_q      <= '0;
            disp_id       <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state         <= state_nx;
            total         <= total_nx;
            change_q      <= change_nx;
            disp_id       <= disp_id_nx;
            coin_reject_q <= coin_reject_nx;
            sel_err_q     <= sel_err_nx;
        end
    end

    assign bus.coin_ready     = coin_ready;
    assign bus.coin_reject    = coin_reject_q;
    assign bus.total_coin     = total;
    assign bus.avail          = avail;
    assign bus.sel_err        = sel_err_q;
    assign bus.dispense_valid = (state == DISPENSE);
    assign bus.dispense_id    = disp_id;
    assign bus.change_valid   = (state == CHANGE);
    assign bus.change         = change_q;

endmodule

// File: tb/tb_vend_fsm_multi.sv
// Bench for vend_fsm_multi: directed scenarios plus a randomized run against a transaction-level credit model.
module tb_vend_fsm_multi;

    localparam int N = 4;
    localparam int W = 8;
    localparam int MAXC = 255;
    localparam int MINP = 10;

    int prices [N] = '{10, 15, 20, 25};

    logic clk = 1'b0;
    logic reset;
    int tests_run = 0;
    int tests_failed = 0;

    vend_fsm_multi_if #(.N_DRINKS(N), .MONEY_W(W)) bus ();

    vend_fsm_multi #(
        .N_DRINKS   (N),
        .MONEY_W    (W),
        .MAX_CREDIT (MAXC),
        .PRICES     ({8'd25, 8'd20, 8'd15, 8'd10})
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Customer-visible model: credit, whether a purchase may be made, and pending events.
    int m_cr, m_id, m_chg;
    bit m_armed, m_disp, m_refund, m_rej, m_serr;

    function automatic void model_step(input bit rst_n, input bit cv, input int c,
                                       input bit sv, input int s, input bit cn);
        int add;
        bit over;
        m_rej = 1'b0;
        m_serr = 1'b0;
        if (!rst_n) begin
            m_cr = 0; m_id = 0; m_chg = 0;
            m_armed = 0; m_disp = 0; m_refund = 0;
            return;
        end
        if (m_disp) begin
            m_disp = 0;
`ifdef MULTI_BUY_EN
            m_armed = (m_cr >= MINP);
`else
            m_armed = 0;
            if (m_cr > 0) begin m_refund = 1; m_chg = m_cr; end
`endif
        end else if (m_refund) begin
            m_refund = 0; m_cr = 0; m_armed = 0;
        end else begin
            over = cv && (m_cr + c > MAXC);
            add = (cv && !over) ? c : 0;
            m_rej = over;
            if (cn && m_cr > 0) begin
                m_cr = m_cr + add; m_chg = m_cr; m_refund = 1; m_armed = 0;
            end else if (m_armed && sv) begin
                if (s < N && m_cr >= prices[s]) begin
                    m_cr = m_cr + add - prices[s]; m_id = s; m_disp = 1; m_armed = 0;
                end else begin
                    m_serr = 1; m_cr = m_cr + add;
                end
            end else begin
                if (sv) m_serr = 1;
                if (!m_armed) m_armed = (m_cr >= MINP);
                m_cr = m_cr + add;
            end
        end
    endfunction

    // One clock: apply inputs, advance the model at the edge, return at the sampling edge.
    task automatic tick(input bit rst_n, input bit cv, input int c,
                        input bit sv, input int s, input bit cn);
        reset = rst_n;
        bus.coin_valid = cv;
        bus.coin = W'(c);
        bus.sel_valid = sv;
        bus.sel = 2'(s);
        bus.cancel = cn;
        @(posedge clk);
        model_step(rst_n, cv, c, sv, s, cn);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.total_coin !== 8'd0) begin tests_failed++; $display("FAIL reset_total got %0d want 0", bus.total_coin); end
        tests_run++; if (bus.coin_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_coin_ready got %b want 1", bus.coin_ready); end
        tests_run++; if (bus.change !== 8'd0 || bus.dispense_id !== 2'd0) begin tests_failed++; $display("FAIL reset_regs got change=%0d id=%0d want 0/0", bus.change, bus.dispense_id); end
        tests_run++;
        if ({bus.coin_reject, bus.sel_err, bus.dispense_valid, bus.change_valid} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_pulses got %b want 0000", {bus.coin_reject, bus.sel_err, bus.dispense_valid, bus.change_valid});
        end
    endtask

    task automatic test_coins();
        do_reset();
        tick(1, 1, 5, 0, 0, 0);
        tick(1, 1, 5, 0, 0, 0);
        tests_run++; if (bus.total_coin !== 8'd10) begin tests_failed++; $display("FAIL coins_total got %0d want 10", bus.total_coin); end
        tests_run++; if (bus.avail !== 4'b0001) begin tests_failed++; $display("FAIL coins_avail got %b want 0001", bus.avail); end
        idle(1);
        tests_run++; if (bus.coin_ready !== 1'b1) begin tests_failed++; $display("FAIL coins_ready got %b want 1", bus.coin_ready); end
        tick(1, 0, 0, 1, 0, 0);
        tests_run++; if (bus.dispense_valid !== 1'b1 || bus.dispense_id !== 2'd0) begin tests_failed++; $display("FAIL coins_tea got dv=%b id=%0d want 1/0", bus.dispense_valid, bus.dispense_id); end
        idle(2);
    endtask

    task automatic test_purchase();
        do_reset();
        tick(1, 1, 10, 0, 0, 0);
        tick(1, 1, 20, 0, 0, 0);
        idle(1);
        tick(1, 0, 0, 1, 2, 0);
        tests_run++; if (bus.dispense_valid !== 1'b1 || bus.dispense_id !== 2'd2) begin tests_failed++; $display("FAIL buy_dispense got dv=%b id=%0d want 1/2", bus.dispense_valid, bus.dispense_id); end
        tests_run++; if (bus.coin_ready !== 1'b0 || bus.total_coin !== 8'd10) begin tests_failed++; $display("FAIL buy_disp_state got rdy=%b total=%0d want 0/10", bus.coin_ready, bus.total_coin); end
        idle(1);
`ifdef MULTI_BUY_EN
        tests_run++; if (bus.change_valid !== 1'b0 || bus.total_coin !== 8'd10 || bus.avail !== 4'b0001) begin tests_failed++; $display("FAIL buy_multi got cv=%b total=%0d avail=%b want 0/10/0001", bus.change_valid, bus.total_coin, bus.avail); end
        tick(1, 0, 0, 1, 0, 0);
        tests_run++; if (bus.dispense_valid !== 1'b1 || bus.dispense_id !== 2'd0 || bus.total_coin !== 8'd0) begin tests_failed++; $display("FAIL buy_multi_second got dv=%b id=%0d total=%0d want 1/0/0", bus.dispense_valid, bus.dispense_id, bus.total_coin); end
        idle(1);
        tests_run++; if (bus.change_valid !== 1'b0) begin tests_failed++; $display("FAIL buy_multi_nochange got %b want 0", bus.change_valid); end
`else
        tests_run++; if (bus.change_valid !== 1'b1 || bus.change !== 8'd10) begin tests_failed++; $display("FAIL buy_change got cv=%b change=%0d want 1/10", bus.change_valid, bus.change); end
        idle(1);
        tests_run++; if (bus.total_coin !== 8'd0 || bus.change_valid !== 1'b0 || bus.change !== 8'd10) begin tests_failed++; $display("FAIL buy_after got total=%0d cv=%b change=%0d want 0/0/10", bus.total_coin, bus.change_valid, bus.change); end
`endif
        idle(1);
    endtask

    task automatic test_sel_err();
        do_reset();
        tick(1, 1, 10, 0, 0, 0);
        tick(1, 1, 5, 0, 0, 0);
        idle(1);
        tick(1, 0, 0, 1, 3, 0);
        tests_run++; if (bus.sel_err !== 1'b1 || bus.total_coin !== 8'd15 || bus.dispense_valid !== 1'b0) begin tests_failed++; $display("FAIL selerr got err=%b total=%0d dv=%b want 1/15/0", bus.sel_err, bus.total_coin, bus.dispense_valid); end
        tick(1, 0, 0, 0, 0, 1);
        tests_run++; if (bus.sel_err !== 1'b0 || bus.change_valid !== 1'b1 || bus.change !== 8'd15) begin tests_failed++; $display("FAIL selerr_cancel got err=%b cv=%b change=%0d want 0/1/15", bus.sel_err, bus.change_valid, bus.change); end
        idle(1);
        tests_run++; if (bus.total_coin !== 8'd0) begin tests_failed++; $display("FAIL selerr_cleared got %0d want 0", bus.total_coin); end
    endtask

    task automatic test_ceiling();
        do_reset();
        tick(1, 1, 250, 0, 0, 0);
        tick(1, 1, 10, 0, 0, 0);
        tests_run++; if (bus.coin_reject !== 1'b1 || bus.total_coin !== 8'd250) begin tests_failed++; $display("FAIL ceil_reject got rej=%b total=%0d want 1/250", bus.coin_reject, bus.total_coin); end
        tick(1, 1, 5, 0, 0, 0);
        tests_run++; if (bus.coin_reject !== 1'b0 || bus.total_coin !== 8'd255) begin tests_failed++; $display("FAIL ceil_exact got rej=%b total=%0d want 0/255", bus.coin_reject, bus.total_coin); end
        tick(1, 1, 0, 0, 0, 1);
        tests_run++; if (bus.change_valid !== 1'b1 || bus.change !== 8'd255) begin tests_failed++; $display("FAIL ceil_refund got cv=%b change=%0d want 1/255", bus.change_valid, bus.change); end
        idle(1);
    endtask

    task automatic test_sel_with_coin();
        do_reset();
        tick(1, 1, 15, 0, 0, 0);
        idle(1);
        tick(1, 1, 5, 1, 1, 0);
        tests_run++; if (bus.dispense_valid !== 1'b1 || bus.dispense_id !== 2'd1 || bus.total_coin !== 8'd5) begin tests_failed++; $display("FAIL selcoin got dv=%b id=%0d total=%0d want 1/1/5", bus.dispense_valid, bus.dispense_id, bus.total_coin); end
`ifdef MULTI_BUY_EN
        idle(1);
        tests_run++; if (bus.change_valid !== 1'b0 || bus.total_coin !== 8'd5) begin tests_failed++; $display("FAIL selcoin_keep got cv=%b total=%0d want 0/5", bus.change_valid, bus.total_coin); end
        tick(1, 0, 0, 0, 0, 1);
`else
        idle(1);
`endif
        tests_run++; if (bus.change_valid !== 1'b1 || bus.change !== 8'd5) begin tests_failed++; $display("FAIL selcoin_change got cv=%b change=%0d want 1/5", bus.change_valid, bus.change); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 1, 20, 0, 0, 0);
        idle(1);
        tick(0, 0, 0, 0, 0, 0);
        tests_run++; if (bus.total_coin !== 8'd0 || bus.coin_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid got total=%0d rdy=%b want 0/1", bus.total_coin, bus.coin_ready); end
        idle(1);
        tests_run++; if (bus.change_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_nochange got %b want 0", bus.change_valid); end
        tick(1, 0, 0, 1, 0, 0);
        tests_run++; if (bus.sel_err !== 1'b1 || bus.dispense_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_collect got err=%b dv=%b want 1/0", bus.sel_err, bus.dispense_valid); end
        idle(1);
    endtask

    task automatic test_random();
        int coins [7] = '{0, 5, 10, 25, 50, 100, 200};
        logic [N-1:0] exp_avail;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit rn, cv, sv, cn;
            int c, s;
            rn = ($urandom_range(0, 99) != 0);
            cv = ($urandom_range(0, 1) == 1);
            c  = coins[$urandom_range(0, 6)];
            sv = ($urandom_range(0, 3) == 0);
            s  = $urandom_range(0, N - 1);
            cn = ($urandom_range(0, 15) == 0);
            tick(rn, cv, c, sv, s, cn);
            for (int i = 0; i < N; i++) exp_avail[i] = (m_cr >= prices[i]);
            tests_run++; if (bus.total_coin !== W'(m_cr)) begin tests_failed++; $display("FAIL rnd_total cyc=%0d got %0d want %0d", cyc, bus.total_coin, m_cr); end
            tests_run++; if (bus.avail !== exp_avail) begin tests_failed++; $display("FAIL rnd_avail cyc=%0d got %b want %b", cyc, bus.avail, exp_avail); end
            tests_run++; if (bus.coin_ready !== !(m_disp || m_refund)) begin tests_failed++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, bus.coin_ready, !(m_disp || m_refund)); end
            tests_run++; if (bus.coin_reject !== m_rej) begin tests_failed++; $display("FAIL rnd_reject cyc=%0d got %b want %b", cyc, bus.coin_reject, m_rej); end
            tests_run++; if (bus.sel_err !== m_serr) begin tests_failed++; $display("FAIL rnd_selerr cyc=%0d got %b want %b", cyc, bus.sel_err, m_serr); end
            tests_run++; if (bus.dispense_valid !== m_disp) begin tests_failed++; $display("FAIL rnd_disp cyc=%0d got %b want %b", cyc, bus.dispense_valid, m_disp); end
            tests_run++; if (bus.dispense_id !== 2'(m_id)) begin tests_failed++; $display("FAIL rnd_id cyc=%0d got %0d want %0d", cyc, bus.dispense_id, m_id); end
            tests_run++; if (bus.change_valid !== m_refund) begin tests_failed++; $display("FAIL rnd_chgv cyc=%0d got %b want %b", cyc, bus.change_valid, m_refund); end
            tests_run++; if (bus.change !== W'(m_chg)) begin tests_failed++; $display("FAIL rnd_change cyc=%0d got %0d want %0d", cyc, bus.change, m_chg); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin = '0;
        bus.sel_valid = 1'b0;
        bus.sel = '0;
        bus.cancel = 1'b0;
        @(negedge clk);
        test_reset();
        test_coins();
        test_purchase();
        test_sel_err();
        test_ceiling();
        test_sel_with_coin();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
